// File: rtl/pad_stimulus_sequencer.sv
// Pad stimulus sequencer: drives one host vector onto the input pads, holds it
// for a settle period, then waits for the sensed output pads to read the same
// value on two consecutive cycles (or gives up after MAX_EXT extra cycles) and
// returns the sampled levels as one result per vector.
module pad_stimulus_sequencer #(
    parameter int unsigned       NIN         = 8,
    parameter int unsigned       NOUT        = 8,
    parameter int unsigned       SETTLE_W    = 8,
    parameter int unsigned       MAX_EXT     = 16,
    parameter logic [NIN-1:0]    RESET_DRIVE = '0
) (
    input  logic                eclk,
    input  logic                erst,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIN-1:0]      in_pins,
    output logic [NIN-1:0]      pin_drive,
    input  logic [NOUT-1:0]     pin_sense,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NOUT-1:0]     out_pins,
    output logic                out_unstable,
    output logic [15:0]         tx_count
);

    localparam int unsigned EXT_W = $clog2(MAX_EXT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        REPORT
    } state_t;

    state_t              state;
    logic [SETTLE_W-1:0] cnt;
    logic [EXT_W-1:0]    ext;
    logic [NOUT-1:0]     prev;

    // Sequencer FSM with every output held in a register.
    // out_valid rises one cycle after REPORT is entered, so the result
    // handshake is only honoured once out_valid is actually visible.
    always_ff @(posedge eclk or negedge erst) begin
        if (!erst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            pin_drive    <= RESET_DRIVE;
            out_valid    <= 1'b0;
            out_pins     <= '0;
            out_unstable <= 1'b0;
            tx_count     <= '0;
            cnt          <= '0;
            ext          <= '0;
            prev         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pin_drive <= in_pins;
                        cnt       <= (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
                        in_ready  <= 1'b0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - SETTLE_W'(1);
                    if (cnt == SETTLE_W'(1)) begin
                        prev  <= pin_sense;
                        ext   <= '0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (pin_sense == prev) begin
                        out_pins     <= pin_sense;
                        out_unstable <= 1'b0;
                        state        <= REPORT;
                    end else begin
                        prev <= pin_sense;
                        ext  <= ext + EXT_W'(1);
                        if (ext == EXT_W'(MAX_EXT - 1)) begin
                            out_pins     <= pin_sense;
                            out_unstable <= 1'b1;
                            state        <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        tx_count  <= tx_count + 16'd1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
